// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Host-side program loader. Takes a byte stream over valid/ready
//            and writes it sequentially into mem from BASE_ADDR. It holds the
//            CPU in reset and owns the mem bus until the load completes, then
//            hands the bus back and releases the CPU.
// Options  : MEM_LOADER_CHECKSUM_EN - one trailer byte follows the payload;
//            the load is only accepted when payload+trailer sums to zero
//            mod 2^DATA_WIDTH, otherwise the loader parks in ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0200,
  parameter int                    LOAD_LEN   = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_sel,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  // Payload length in the width of the byte counter (LOAD_LEN may equal
  // 2^ADDR_WIDTH, hence the extra counter bit).
  localparam logic [ADDR_WIDTH:0] LEN = (ADDR_WIDTH+1)'(LOAD_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    CHECK = 3'd3,
    ERROR = 3'd4
`endif
  } state_t;

  state_t state;

  logic              xfer;
  logic              last_byte;
  logic              restart;
  logic [ADDR_WIDTH:0] count_next;

  assign xfer       = byte_valid && byte_ready;
  assign count_next = count + 1'b1;
  assign last_byte  = (count_next == LEN);

  // A new load may begin from any non-busy state; start while busy is dropped.
`ifdef MEM_LOADER_CHECKSUM_EN
  assign restart = start && (state == IDLE || state == RUN || state == ERROR);
`else
  assign restart = start && (state == IDLE || state == RUN);
`endif

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_next;

  assign sum_next = sum + byte_data;
`else
  assign error = 1'b0;
`endif

  // Load sequencer; every output is registered so the mem mux and the CPU
  // reset see glitch-free controls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cpu_reset_n <= 1'b0;
      mem_sel     <= 1'b1;
      byte_ready  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_din     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      error       <= 1'b0;
      sum         <= '0;
`endif
    end else begin
      // Write strobe lasts exactly one cycle per accepted payload byte.
      mem_we <= 1'b0;

      case (state)
        IDLE: begin
          cpu_reset_n <= 1'b0;
          mem_sel     <= 1'b1;
        end

        LOAD: begin
          if (xfer) begin
            mem_we   <= 1'b1;
            mem_addr <= BASE_ADDR + count[ADDR_WIDTH-1:0];
            mem_din  <= byte_data;
            count    <= count_next;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum      <= sum_next;
            if (last_byte) begin
              // Stay ready: the trailer byte is accepted in CHECK.
              state <= CHECK;
            end
`else
            if (last_byte) begin
              byte_ready <= 1'b0;
              state      <= RUN;
            end
`endif
          end
        end

`ifdef MEM_LOADER_CHECKSUM_EN
        CHECK: begin
          // Trailer is consumed but never written to mem.
          if (xfer) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            sum        <= sum_next;
            if (sum_next == '0) begin
              state <= RUN;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end

        ERROR: begin
          error       <= 1'b1;
          done        <= 1'b0;
          cpu_reset_n <= 1'b0;
          mem_sel     <= 1'b1;
          busy        <= 1'b0;
        end
`endif

        RUN: begin
          // Hand-over happens one cycle after entry, so the final write
          // still sees mem_sel=1.
          mem_sel     <= 1'b0;
          cpu_reset_n <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
        end

        default: state <= IDLE;
      endcase

      // Begin (or re-begin) a load: reclaim the bus and re-assert CPU reset
      // in the same edge so the CPU never runs against a half-written image.
      if (restart) begin
        state       <= LOAD;
        mem_sel     <= 1'b1;
        cpu_reset_n <= 1'b0;
        done        <= 1'b0;
        byte_ready  <= 1'b1;
        busy        <= 1'b1;
        count       <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
        error       <= 1'b0;
        sum         <= '0;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Directed bench for mem_loader. Two instances share the host byte
//            stream: one loads at 16'h0200, the other at 16'hFFFE to exercise
//            address wrap. Each instance is started separately.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        ready0, we0, sel0, cpurst0, busy0, done0, err0;
  logic [15:0] addr0;
  logic [7:0]  din0;
  logic [16:0] count0;
  logic        ready1, we1, sel1, cpurst1, busy1, done1, err1;
  logic [15:0] addr1;
  logic [7:0]  din1;
  logic [16:0] count1;

  mem_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(16'h0200), .LOAD_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready0),
    .mem_we(we0), .mem_addr(addr0), .mem_din(din0), .mem_sel(sel0),
    .cpu_reset_n(cpurst0), .busy(busy0), .done(done0), .error(err0), .count(count0)
  );

  mem_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(16'hFFFE), .LOAD_LEN(4)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready1),
    .mem_we(we1), .mem_addr(addr1), .mem_din(din1), .mem_sel(sel1),
    .cpu_reset_n(cpurst1), .busy(busy1), .done(done1), .error(err1), .count(count1)
  );

  always #5 clk = ~clk;

  // Write log: what mem would capture on each strobe, with the cycle index.
  int cyc = 0;
  int wa0[$];
  int wd0[$];
  int wc0[$];
  int wa1[$];
  int wd1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we0) begin
      wa0.push_back(int'(addr0));
      wd0.push_back(int'(din0));
      wc0.push_back(cyc);
    end
    if (we1) begin
      wa1.push_back(int'(addr1));
      wd1.push_back(int'(din1));
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int base0    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dut(input bit which);
    if (which) start1 = 1'b1;
    else       start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Trailer that makes payload + trailer sum to zero mod 256.
  function automatic logic [7:0] good_trailer(input logic [31:0] p);
    return 8'h00 - (p[31:24] + p[23:16] + p[15:8] + p[7:0]);
  endfunction

  // Drives the payload (plus trailer when the checksum feature is built),
  // either back-to-back or with byte_valid low between bytes.
  task automatic send(input logic [31:0] payload, input logic [7:0] trailer, input bit alt);
    for (int i = 0; i < NBYTES; i++) begin
      byte_valid = 1'b1;
      byte_data  = (i < 4) ? payload[31-8*i -: 8] : trailer;
      tick(1);
      if (alt && i != NBYTES-1) begin
        byte_valid = 1'b0;
        tick(1);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int qa[$], input int qd[$],
                              input int first, input int base, input logic [31:0] payload);
    check($sformatf("%s_nwrites", tag), 32'(qa.size() - first), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (first + i < qa.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(qa[first+i]), 32'((base + i) & 'hFFFF));
        check($sformatf("%s_data%0d", tag, i), 32'(qd[first+i]), 32'(payload[31-8*i -: 8]));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick(2);
    check("rst_cpu_reset_n", cpurst0, 0);
    check("rst_mem_sel", sel0, 1);
    check("rst_byte_ready", ready0, 0);
    check("rst_mem_we", we0, 0);
    check("rst_mem_addr", addr0, 32'h0200);
    check("rst_mem_addr_wrap", addr1, 32'hFFFE);
    check("rst_count", count0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_error", err0, 0);

    reset_n = 1'b1;
    tick(5);
    check("idle_cpu_reset_n", cpurst0, 0);
    check("idle_mem_sel", sel0, 1);
    check("idle_byte_ready", ready0, 0);
    check("idle_done", done0, 0);

    // Back-to-back load
    start_dut(0);
    check("t1_busy", busy0, 1);
    check("t1_byte_ready", ready0, 1);
    check("t1_count_clr", count0, 0);
    base0 = wa0.size();
    send(32'hA9058D00, good_trailer(32'hA9058D00), 1'b0);
    check("t1_ready_drop", ready0, 0);
`ifndef MEM_LOADER_CHECKSUM_EN
    check("t1_last_we", we0, 1);
    check("t1_last_addr", addr0, 32'h0203);
    check("t1_last_sel", sel0, 1);
`endif
    tick(1);
    check("t1_done", done0, 1);
    check("t1_cpu_reset_n", cpurst0, 1);
    check("t1_mem_sel", sel0, 0);
    check("t1_busy_low", busy0, 0);
    check("t1_count", count0, 4);
    check_writes("t1", wa0, wd0, base0, 32'h0200, 32'hA9058D00);
    if (wc0.size() >= base0 + 4)
      check("t1_consecutive", 32'(wc0[base0+3] - wc0[base0]), 32'd3);

    // Reload from RUN with byte_valid low on alternate cycles
    start_dut(0);
    check("t2_mem_sel", sel0, 1);
    check("t2_cpu_reset_n", cpurst0, 0);
    check("t2_done_clr", done0, 0);
    check("t2_count_clr", count0, 0);
    base0 = wa0.size();
    send(32'h11223344, good_trailer(32'h11223344), 1'b1);
    tick(1);
    check("t2_done", done0, 1);
    check("t2_count", count0, 4);
    check_writes("t2", wa0, wd0, base0, 32'h0200, 32'h11223344);
    if (wc0.size() >= base0 + 2)
      check("t2_spacing", 32'(wc0[base0+1] - wc0[base0]), 32'd2);

    // byte_valid outside a load is ignored by both instances
    base0 = wa0.size();
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    tick(3);
    byte_valid = 1'b0;
    check("idle_valid_ready", ready0, 0);
    check("idle_valid_nwrites", 32'(wa0.size() - base0), 0);
    check("idle_valid_count", count0, 4);
    check("idle_valid_done", done0, 1);
    check("wrap_untouched", 32'(wa1.size()), 0);

    // Address wrap at the top of memory
    start_dut(1);
    send(32'hDEADBEEF, good_trailer(32'hDEADBEEF), 1'b0);
    tick(1);
    check("t3_done", done1, 1);
    check_writes("t3", wa1, wd1, 0, 'hFFFE, 32'hDEADBEEF);

    // Reset after two of four bytes
    start_dut(0);
    base0 = wa0.size();
    byte_valid = 1'b1;
    byte_data  = 8'hC1;
    tick(1);
    byte_data  = 8'hC2;
    tick(1);
    byte_valid = 1'b0;
    tick(1);
    reset_n = 1'b0;
    #1;
    check("t4_busy", busy0, 0);
    check("t4_cpu_reset_n", cpurst0, 0);
    check("t4_count", count0, 0);
    check("t4_byte_ready", ready0, 0);
    check("t4_mem_sel", sel0, 1);
    check("t4_wrap_cpu_reset_n", cpurst1, 0);
    check("t4_partial_n", 32'(wa0.size() - base0), 2);
    if (wa0.size() >= base0 + 2) begin
      check("t4_partial_addr1", 32'(wa0[base0+1]), 32'h0201);
      check("t4_partial_data1", 32'(wd0[base0+1]), 32'hC2);
    end
    tick(1);
    reset_n = 1'b1;
    tick(1);
    start_dut(0);
    base0 = wa0.size();
    send(32'h5AA53CC3, good_trailer(32'h5AA53CC3), 1'b0);
    tick(1);
    check("t4_reload_done", done0, 1);
    check_writes("t4_reload", wa0, wd0, base0, 32'h0200, 32'h5AA53CC3);

`ifdef MEM_LOADER_CHECKSUM_EN
    // Good trailer
    start_dut(0);
    base0 = wa0.size();
    send(32'h01020304, 8'hF6, 1'b0);
    tick(1);
    check("t5_done", done0, 1);
    check("t5_error", err0, 0);
    check("t5_trailer_not_written", 32'(wa0.size() - base0), 4);
    // Bad trailer
    start_dut(0);
    send(32'h01020304, 8'hF5, 1'b0);
    check("t5_bad_error", err0, 1);
    check("t5_bad_cpu_reset_n", cpurst0, 0);
    tick(1);
    check("t5_bad_done", done0, 0);
    check("t5_bad_mem_sel", sel0, 1);
    check("t5_bad_error_hold", err0, 1);
    // Restart clears the error
    start_dut(0);
    check("t5_restart_error", err0, 0);
    check("t5_restart_busy", busy0, 1);
`else
    check("no_checksum_error", err0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Host-side program loader and the write-side counterpart of the fetcher.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into mem starting at BASE_ADDR.
- Holds the CPU in reset and owns the mem bus until the load completes, then hands the bus back and releases the CPU.
- Replaces bench-driven manual_mem loading with synthesizable logic.

Parameters:
- ADDR_WIDTH, 16, mem address width.
- DATA_WIDTH, 8, byte width; matches REG_WIDTH.
- BASE_ADDR, 16'h0200, first address written.
- LOAD_LEN, 256, payload bytes per load; legal range 1..2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; phi2 domain, same edge as mem.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- byte_valid  in  1  host byte is present.
- byte_data  in  DATA_WIDTH  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  write strobe to mem.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_din  out  DATA_WIDTH  write data.
- mem_sel  out  1  1 = loader drives the mem addr/din/we mux; 0 = CPU/fetcher drives it.
- cpu_reset_n  out  1  reset to the CPU blocks (fetcher, decoder, regs, bus).
- busy  out  1  in LOAD or CHECK.
- done  out  1  load finished successfully.
- error  out  1  checksum failure; only driven with the optional feature.
- count  out  ADDR_WIDTH+1  bytes accepted in the current load.

Behaviour:
- Reset values (async, immediate on reset_n low):
  - state=IDLE, cpu_reset_n=0, mem_sel=1.
  - byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0.
  - busy=0, done=0, error=0, count=0.
- States: IDLE, LOAD, CHECK (optional feature only), RUN, ERROR.
- IDLE: cpu_reset_n=0, mem_sel=1. start -> LOAD; count cleared, idx cleared.
- LOAD:
  - byte_ready=1, busy=1.
  - A byte transfers on any cycle with byte_valid and byte_ready both high at the clk edge.
  - Write latency: a byte accepted at edge N gives mem_we=1, mem_addr=BASE_ADDR+idx, mem_din=byte on cycle N..N+1; that write commits at edge N+1.
  - mem_we=0 on cycles with no transfer.
  - Back-to-back transfers sustain 1 byte/cycle.
- Address arithmetic: BASE_ADDR+idx, truncated to ADDR_WIDTH; wraps 16'hFFFF -> 16'h0000.
- count increments per transfer and saturates at LOAD_LEN.
- On the transfer that makes count==LOAD_LEN:
  - byte_ready drops from the next cycle.
  - The final write still issues.
  - Next state is RUN (feature off) or CHECK (feature on).
- RUN:
  - Entered the cycle after the last write strobe.
  - mem_sel=0, cpu_reset_n=1, done=1, busy=0.
  - Outputs stay stable until start or reset.
- start in RUN or ERROR: mem_sel=1 and cpu_reset_n=0 the next cycle, done=0, error=0, then LOAD.
- start while busy: ignored.
- byte_valid outside LOAD/CHECK: ignored; byte_ready=0.
- No transfer is lost or duplicated when byte_valid toggles. The host holds byte_data while byte_valid && !byte_ready.
- Reset mid-load: state returns to IDLE immediately; the partial mem contents remain; the CPU stays in reset.
- cpu_reset_n never pulses high outside RUN.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - After LOAD_LEN payload bytes, enter CHECK with byte_ready=1; busy=1.
  - Accept exactly one trailer byte; it is not written to mem (mem_we=0).
  - Running sum = (sum of payload + trailer) mod 2^DATA_WIDTH.
  - Sum==0 -> RUN.
  - Sum!=0 -> ERROR: error=1, done=0, cpu_reset_n=0, mem_sel=1.
- Not defined:
  - CHECK and ERROR states are absent; error is tied 0.
  - LOAD goes directly to RUN.

Test Plan:
- Reset, then idle 5 cycles -> cpu_reset_n=0, mem_sel=1, byte_ready=0, done=0.
- LOAD_LEN=4, BASE_ADDR=16'h0200, start, stream A9,05,8D,00 back-to-back -> mem_we on 4 consecutive cycles at 0200..0203.
  - Then done=1, cpu_reset_n=1, mem_sel=0; mem readback matches.
- Same load with byte_valid low on alternate cycles -> still exactly 4 writes; addresses contiguous; count=4.
- BASE_ADDR=16'hFFFE, LOAD_LEN=4 -> writes to FFFE, FFFF, 0000, 0001.
- Assert reset_n low after 2 of 4 bytes -> immediate IDLE, cpu_reset_n=0, count=0.
  - A new start reloads from 0200.
- With MEM_LOADER_CHECKSUM_EN, payload 01,02,03,04 plus trailer F6 -> done=1.
  - Trailer F5 -> error=1, cpu_reset_n=0.
  - A subsequent start clears error.
